// File: rtl/decoder_arb_pkg.sv
// Shared types and helpers for the round-robin decoder arbiter.
package decoder_arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Requester indices wrap naturally at IDX_W bits.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] p);
    return p + IDX_W'(1);
  endfunction
endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set req bit at or after ptr+1, mod 8.
// Rotate so the search starts at bit 0, priority-encode, then add the rotation back.
module rr_pick8
  import decoder_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] winner
);
  logic [IDX_W-1:0]   start;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  always_comb begin
    start = next_idx(ptr);
    dbl   = {req, req} >> start;
    rot   = dbl[N_REQ-1:0];
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    winner = start + off;
    any    = |req;
  end
endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin owner of the 3-to-8 decoder inputs {A,B,C,E}; grant 1 cycle after a request is seen in IDLE.
// Grants are bounded by MAX_HOLD when others wait, with a GAP_CYCLES E-low gap between grants.
module decoder_rr_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int MAX_HOLD   = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             E,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             timeout
);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             e_q, e_d;
  logic             timeout_q, timeout_d;

  logic             any;
  logic [IDX_W-1:0] winner;
  logic             others;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (any),
    .winner (winner)
  );

  assign others = |(req & ~(N_REQ'(1) << gnt_idx_q));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_idx_d  = gnt_idx_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    e_d        = e_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        gap_cnt_d  = '0;
        if (en && any) begin
          state_d   = GRANT;
          gnt_idx_d = winner;
          ptr_d     = winner;
          e_d       = 1'b1;
        end
      end
      GRANT: begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        // A release on the expiry cycle wins over the timeout.
        if (!en) begin
          state_d    = IDLE;
          e_d        = 1'b0;
          hold_cnt_d = '0;
        end else if (!req[gnt_idx_q]) begin
          state_d    = GAP;
          e_d        = 1'b0;
          hold_cnt_d = '0;
          gap_cnt_d  = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          if (others) begin
            state_d   = GAP;
            e_d       = 1'b0;
            gap_cnt_d = '0;
            timeout_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (!en || gap_cnt_q == GAP_LAST) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        e_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '1;
      gnt_idx_q  <= '0;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      e_q        <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      e_q        <= e_d;
      timeout_q  <= timeout_d;
    end
  end

  assign E       = e_q;
  assign A       = gnt_idx_q[2];
  assign B       = gnt_idx_q[1];
  assign C       = gnt_idx_q[0];
  assign gnt_idx = gnt_idx_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Scoreboard bench: two arbiters (MAX_HOLD 16 and 4) share stimulus; each drives a decoder model.
module tb_decoder_rr_arbiter;
  typedef struct packed {
    logic       e;
    logic [2:0] idx;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;

  logic       a16, b16, c16, e16, to16;
  logic [2:0] gi16;
  logic       a4, b4, c4, e4, to4;
  logic [2:0] gi4;
  logic [7:0] d16, d4;

  int errors = 0;
  int checks = 0;

  exp_t q16[$];
  exp_t q4[$];

  int m_ptr[2], m_idx[2], m_on[2], m_held[2], m_gap[2];
  int maxh[2] = '{16, 4};

  always #5 clk = ~clk;

  decoder_rr_arbiter #(.MAX_HOLD(16), .GAP_CYCLES(1)) u16 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .A(a16), .B(b16), .C(c16), .E(e16), .gnt_idx(gi16), .timeout(to16)
  );

  decoder_rr_arbiter #(.MAX_HOLD(4), .GAP_CYCLES(1)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .A(a4), .B(b4), .C(c4), .E(e4), .gnt_idx(gi4), .timeout(to4)
  );

  // The shared 3-to-8 decoder, one copy per arbiter.
  assign d16 = e16 ? (8'h01 << {a16, b16, c16}) : 8'h00;
  assign d4  = e4  ? (8'h01 << {a4, b4, c4})    : 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_ptr[k]  = 7;
    m_idx[k]  = 0;
    m_on[k]   = 0;
    m_held[k] = 0;
    m_gap[k]  = 0;
  endtask

  // Behavioural rules: who owns the decoder after the next edge.
  task automatic model_step(input int k, input logic en_i, input logic [7:0] req_i, output exp_t r);
    bit to = 0;
    bit others = 0;
    for (int j = 0; j < 8; j++)
      if (j != m_idx[k] && req_i[j]) others = 1;
    if (m_on[k] != 0) begin
      if (!en_i) begin
        m_on[k] = 0;
      end else if (!req_i[m_idx[k]]) begin
        m_on[k] = 0;
        m_gap[k] = 1;
      end else if (m_held[k] == maxh[k]) begin
        if (others) begin
          m_on[k] = 0;
          m_gap[k] = 1;
          to = 1;
        end else begin
          m_held[k] = 1;
        end
      end else begin
        m_held[k]++;
      end
    end else if (m_gap[k] > 0) begin
      m_gap[k] = en_i ? m_gap[k] - 1 : 0;
    end else if (en_i && req_i != 8'h00) begin
      for (int i = 1; i <= 8; i++) begin
        int c = (m_ptr[k] + i) % 8;
        if (req_i[c]) begin
          m_ptr[k] = c;
          m_idx[k] = c;
          m_on[k] = 1;
          m_held[k] = 1;
          break;
        end
      end
    end
    r.e = (m_on[k] != 0);
    r.idx = 3'(m_idx[k]);
    r.to = to;
  endtask

  task automatic push_all(input logic rst_i);
    exp_t r;
    for (int k = 0; k < 2; k++) begin
      if (!rst_i) begin
        model_reset(k);
        r = '{e: 1'b0, idx: 3'd0, to: 1'b0};
      end else begin
        model_step(k, en, req, r);
      end
      if (k == 0) q16.push_back(r);
      else q4.push_back(r);
    end
  endtask

  task automatic cyc(input logic rst_i, input logic en_i, input logic [7:0] req_i);
    @(negedge clk);
    #1;
    rst_n = rst_i;
    en = en_i;
    req = req_i;
    push_all(rst_i);
  endtask

  task automatic run(input int n, input logic en_i, input logic [7:0] req_i);
    for (int i = 0; i < n; i++) cyc(1'b1, en_i, req_i);
  endtask

  // Reset pulse between edges: E must fall before the next clock edge.
  task automatic pulse_reset(input logic en_i, input logic [7:0] req_i);
    @(negedge clk);
    #1;
    en = en_i;
    req = req_i;
    rst_n = 1'b0;
    #1;
    chk("async_e16", e16, 0);
    chk("async_e4", e4, 0);
    chk("async_idx16", gi16, 0);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) model_reset(k);
    push_all(1'b1);
  endtask

  task automatic cmp(input string tag, input exp_t x, input logic e_a, input logic [2:0] gi_a,
                     input logic [2:0] abc_a, input logic [7:0] d_a, input logic to_a);
    chk({tag, "_E"}, e_a, x.e);
    chk({tag, "_idx"}, gi_a, x.idx);
    chk({tag, "_abc"}, abc_a, x.idx);
    chk({tag, "_D"}, d_a, x.e ? (8'h01 << x.idx) : 8'h00);
    chk({tag, "_timeout"}, to_a, x.to);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q16.size() > 0) begin
        x = q16.pop_front();
        cmp("h16", x, e16, gi16, {a16, b16, c16}, d16, to16);
      end
      if (q4.size() > 0) begin
        x = q4.pop_front();
        cmp("h4", x, e4, gi4, {a4, b4, c4}, d4, to4);
      end
    end
  end

  initial begin : stimulus
    logic [7:0] r;
    logic       e;
    for (int k = 0; k < 2; k++) model_reset(k);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'hFF);
    run(3, 1'b1, 8'hFF);
    run(4, 1'b1, 8'h00);
    run(5, 1'b1, 8'h20);
    run(4, 1'b1, 8'h00);
    run(40, 1'b1, 8'h91);
    run(4, 1'b1, 8'h00);
    run(40, 1'b1, 8'h08);
    run(4, 1'b1, 8'h00);
    run(3, 1'b1, 8'h04);
    run(1, 1'b0, 8'h04);
    run(4, 1'b1, 8'h06);
    run(4, 1'b1, 8'h00);
    run(3, 1'b1, 8'h04);
    pulse_reset(1'b1, 8'h81);
    run(3, 1'b1, 8'h81);
    run(3, 1'b1, 8'h00);
    r = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) r = 8'($urandom);
      e = ($urandom_range(9) != 0);
      if ($urandom_range(59) == 0) pulse_reset(e, r);
      else cyc(1'b1, e, r);
    end
    run(2, 1'b1, 8'h00);
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
